// File: rtl/ehl_gray_counter_if.sv
// Bundles the control inputs and count outputs of ehl_gray_counter.
// The master side drives the controls; the slave side is the counter itself.
interface ehl_gray_counter_if #(
  parameter int WIDTH = 5
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             down;
  logic [WIDTH-1:0] count_bin;
  logic [WIDTH-1:0] count_gray;
  logic [WIDTH-1:0] count_gray_next;
  logic             wrap;

  modport master (
    output clear, load, load_value, enable, down,
    input  count_bin, count_gray, count_gray_next, wrap
  );

  modport slave (
    input  clear, load, load_value, enable, down,
    output count_bin, count_gray, count_gray_next, wrap
  );
endinterface

// File: rtl/ehl_gray_counter.sv
// Up/down counter holding binary and Gray copies of its value, with clear,
// load, optional saturation and a combinational look-ahead Gray output.
module ehl_gray_counter #(
  parameter int          WIDTH    = 5,
  parameter int unsigned INIT     = 0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  ehl_gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  localparam logic [WIDTH-1:0] INIT_GRAY_V = INIT_V ^ (INIT_V >> 1);

  logic [WIDTH-1:0] count_bin_r;
  logic [WIDTH-1:0] count_gray_r;
  logic             wrap_r;
  logic [WIDTH-1:0] next_bin_s;
  logic             next_wrap_s;

  // Next-state selection: clear > load > step > hold; shared by registers and look-ahead.
  always_comb begin
    next_bin_s  = count_bin_r;
    next_wrap_s = 1'b0;
    if (bus.clear) begin
      next_bin_s = INIT_V;
    end else if (bus.load) begin
      next_bin_s = bus.load_value;
    end else if (bus.enable) begin
      if (bus.down) begin
        if (count_bin_r == ZERO_V) begin
          if (SATURATE) begin
            next_bin_s = ZERO_V;
          end else begin
            next_bin_s  = MAX_V;
            next_wrap_s = 1'b1;
          end
        end else begin
          next_bin_s = count_bin_r - ONE_V;
        end
      end else begin
        if (count_bin_r == MAX_V) begin
          if (SATURATE) begin
            next_bin_s = MAX_V;
          end else begin
            next_bin_s  = ZERO_V;
            next_wrap_s = 1'b1;
          end
        end else begin
          next_bin_s = count_bin_r + ONE_V;
        end
      end
    end else begin
      next_bin_s = count_bin_r;
    end
  end

  // Both count copies update on the same edge so they can never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_bin_r  <= INIT_V;
      count_gray_r <= INIT_GRAY_V;
      wrap_r       <= 1'b0;
    end else begin
      count_bin_r  <= next_bin_s;
      count_gray_r <= bin2gray(next_bin_s);
      wrap_r       <= next_wrap_s;
    end
  end

  assign bus.count_bin       = count_bin_r;
  assign bus.count_gray      = count_gray_r;
  assign bus.count_gray_next = bin2gray(next_bin_s);
  assign bus.wrap            = wrap_r;

endmodule
